alu: RTL and testbench

// - Integer ALU of the ARM-style execute stage; computes one of nine ops on two WIDTH-bit operands.
// - Result and NZCV flags registered: one-cycle latency into the EXE/MEM boundary and the status register.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_adder.sv | 24 ++
 rtl/alu.sv | 119 +++++++++++
 tb/tb_alu.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: command encodings and status-bit positions.
// Used by alu and alu_adder; the optional illegal-command output is controlled by ALU_ILLEGAL_CMD_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    // True only for the nine encodings above; 0000 and 1010..1111 are undefined.
    function automatic logic is_defined_cmd(input logic [3:0] cmd);
        logic ok;
        ok = 1'b0;
        case (cmd)
            CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
            CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Commands that route through the shared adder.
    function automatic logic is_arith_cmd(input logic [3:0] cmd);
        logic ok;
        ok = 1'b0;
        case (cmd)
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder with carry-in, reporting carry-out and signed overflow.
// One instance serves ADD/ADC/SUB/SBC; the caller pre-inverts b for subtraction.
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum  = full[WIDTH-1:0];
        cout = full[WIDTH];
        // Overflow: both adder inputs share a sign and the result sign differs.
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: nine ops, registered result and {N,Z,C,V} with one-cycle latency.
// Define ALU_ILLEGAL_CMD_EN to add the registered illegalCmd output for undefined EXE_CMD codes.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    input  logic             carryIn,
    input  logic [3:0]       EXE_CMD,
    output logic [3:0]       status,
`ifdef ALU_ILLEGAL_CMD_EN
    output logic             illegalCmd,
`endif
    output logic [WIDTH-1:0] ALUResult
);

    // Interface contract: no handshake; a new operation is accepted on every rising
    // edge with rst_n high, and its result appears on the outputs after that edge.

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    logic [WIDTH-1:0] result_next;
    logic [3:0]       status_next;
    logic             arith;

    // Operand/carry steering for the shared adder.
    always_comb begin
        add_b   = value2;
        add_cin = 1'b0;
        case (EXE_CMD)
            CMD_ADD: begin
                add_b   = value2;
                add_cin = 1'b0;
            end
            CMD_ADC: begin
                add_b   = value2;
                add_cin = carryIn;
            end
            CMD_SUB: begin
                add_b   = ~value2;
                add_cin = 1'b1;
            end
            CMD_SBC: begin
                add_b   = ~value2;
                add_cin = carryIn;
            end
            default: begin
                add_b   = value2;
                add_cin = 1'b0;
            end
        endcase
    end

    alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (value1),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    always_comb begin
        result_next = '0;
        case (EXE_CMD)
            CMD_MOV: result_next = value2;
            CMD_MVN: result_next = ~value2;
            CMD_ADD,
            CMD_ADC,
            CMD_SUB,
            CMD_SBC: result_next = add_sum;
            CMD_AND: result_next = value1 & value2;
            CMD_ORR: result_next = value1 | value2;
            CMD_EOR: result_next = value1 ^ value2;
            default: result_next = '0;
        endcase
    end

    // C and V are only meaningful for adder ops; logical/move/undefined clear them.
    always_comb begin
        arith                 = is_arith_cmd(EXE_CMD);
        status_next           = 4'b0000;
        status_next[STATUS_N] = result_next[WIDTH-1];
        status_next[STATUS_Z] = (result_next == '0);
        status_next[STATUS_C] = arith & add_cout;
        status_next[STATUS_V] = arith & add_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult <= '0;
            status    <= 4'b0000;
        end else begin
            ALUResult <= result_next;
            status    <= status_next;
        end
    end

`ifdef ALU_ILLEGAL_CMD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegalCmd <= 1'b0;
        end else begin
            illegalCmd <= ~is_defined_cmd(EXE_CMD);
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu at WIDTH=4 with hand-computed result/flag vectors.
// Also exercises illegalCmd when built with ALU_ILLEGAL_CMD_EN.
module tb_alu;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic             carryIn;
    logic [3:0]       EXE_CMD;
    logic [3:0]       status;
    logic [WIDTH-1:0] ALUResult;
`ifdef ALU_ILLEGAL_CMD_EN
    logic             illegalCmd;
`endif

    int checks = 0;
    int errors = 0;

    alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value1    (value1),
        .value2    (value2),
        .carryIn   (carryIn),
        .EXE_CMD   (EXE_CMD),
        .status    (status),
`ifdef ALU_ILLEGAL_CMD_EN
        .illegalCmd(illegalCmd),
`endif
        .ALUResult (ALUResult)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_rs(input string tag,
                            input logic [WIDTH-1:0] exp_r,
                            input logic [3:0] exp_s);
        checks++;
        assert (ALUResult === exp_r) else begin
            errors++;
            $error("FAIL %s result observed=%b expected=%b", tag, ALUResult, exp_r);
        end
        checks++;
        assert (status === exp_s) else begin
            errors++;
            $error("FAIL %s status observed=%b expected=%b", tag, status, exp_s);
        end
    endtask

    // Drive one op away from the edge, clock it in, sample 1 time unit later.
    task automatic apply(input logic [3:0] cmd, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
        @(negedge clk);
        EXE_CMD = cmd;
        value1  = a;
        value2  = b;
        carryIn = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] cmd,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] exp_r,
                          input logic [3:0] exp_s);
        apply(cmd, a, b, cin);
        check_rs(tag, exp_r, exp_s);
    endtask

    initial begin
        rst_n   = 1'b0;
        value1  = '0;
        value2  = '0;
        carryIn = 1'b0;
        EXE_CMD = 4'b0000;
        #12;
        check_rs("reset_state", 4'b0000, 4'b0000);
`ifdef ALU_ILLEGAL_CMD_EN
        checks++;
        assert (illegalCmd === 1'b0) else begin
            errors++;
            $error("FAIL reset_illegal observed=%b expected=0", illegalCmd);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // A=1, B=4 basic ops
        run_op("mov",        4'b0001, 4'd1, 4'd4, 1'b0, 4'b0100, 4'b0000);
        run_op("mov_cin",    4'b0001, 4'd1, 4'd4, 1'b1, 4'b0100, 4'b0000);
        run_op("mvn",        4'b1001, 4'd1, 4'd4, 1'b0, 4'b1011, 4'b1000);
        run_op("add",        4'b0010, 4'd1, 4'd4, 1'b0, 4'b0101, 4'b0000);
        run_op("add_cin1",   4'b0010, 4'd1, 4'd4, 1'b1, 4'b0101, 4'b0000);
        run_op("adc_cin1",   4'b0011, 4'd1, 4'd4, 1'b1, 4'b0110, 4'b0000);
        run_op("sub",        4'b0100, 4'd1, 4'd4, 1'b1, 4'b1101, 4'b1000);
        run_op("sbc_cin1",   4'b0101, 4'd1, 4'd4, 1'b1, 4'b1101, 4'b1000);
        run_op("sbc_cin0",   4'b0101, 4'd1, 4'd4, 1'b0, 4'b1100, 4'b1000);
        run_op("and",        4'b0110, 4'd1, 4'd4, 1'b0, 4'b0000, 4'b0100);
        run_op("orr",        4'b0111, 4'd1, 4'd4, 1'b0, 4'b0101, 4'b0000);
        run_op("eor",        4'b1000, 4'd1, 4'd4, 1'b0, 4'b0101, 4'b0000);
        run_op("cmd0000",    4'b0000, 4'd1, 4'd4, 1'b1, 4'b0000, 4'b0100);

        // Boundaries
        run_op("add_ovf",    4'b0010, 4'd1,  4'd7, 1'b0, 4'b1000, 4'b1001);
        run_op("add_wrap",   4'b0010, 4'd15, 4'd1, 1'b0, 4'b0000, 4'b0110);
        run_op("sub_equal",  4'b0100, 4'd4,  4'd4, 1'b0, 4'b0000, 4'b0110);
        run_op("sub_noborr", 4'b0100, 4'd4,  4'd1, 1'b0, 4'b0011, 4'b0010);
        run_op("sub_vneg",   4'b0100, 4'd8,  4'd1, 1'b0, 4'b0111, 4'b0011);
        run_op("adc_wrap",   4'b0011, 4'd15, 4'd0, 1'b1, 4'b0000, 4'b0110);
        run_op("eor_self",   4'b1000, 4'd9,  4'd9, 1'b1, 4'b0000, 4'b0100);
        run_op("orr_neg",    4'b0111, 4'd8,  4'd3, 1'b1, 4'b1011, 4'b1000);
        run_op("cmd1111",    4'b1111, 4'd7,  4'd7, 1'b1, 4'b0000, 4'b0100);
`ifdef ALU_ILLEGAL_CMD_EN
        checks++;
        assert (illegalCmd === 1'b1) else begin
            errors++;
            $error("FAIL illegal_1111 observed=%b expected=1", illegalCmd);
        end
        run_op("add_legal",  4'b0010, 4'd2, 4'd3, 1'b0, 4'b0101, 4'b0000);
        checks++;
        assert (illegalCmd === 1'b0) else begin
            errors++;
            $error("FAIL illegal_0010 observed=%b expected=0", illegalCmd);
        end
`endif

        // Mid-run async reset: outputs clear without a clock edge.
        run_op("pre_reset",  4'b1001, 4'd0, 4'd0, 1'b0, 4'b1111, 4'b1000);
        @(negedge clk);
        EXE_CMD = 4'b0010;
        value1  = 4'd3;
        value2  = 4'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check_rs("async_reset", 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        check_rs("reset_held", 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_rs("post_reset", 4'b0110, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
